// File: rtl/pkg_graybin.sv
// Shared constants and types for the async FIFO write domain.
package pkg_graybin;
    localparam int DATASIZE = 8;
    localparam int STAT_W   = 16;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/wr_chan_arb_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping at NCHAN.
module rr_pick #(
    parameter int NCHAN = 4,
    localparam int IW = $clog2(NCHAN)
) (
    input  logic [NCHAN-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_any
);
    logic found;
    int   c;

    always_comb begin
        gnt_idx = '0;
        gnt_any = |req;
        found   = 1'b0;
        c       = 0;
        for (int k = 0; k < NCHAN; k++) begin
            // explicit wrap so non-power-of-two NCHAN stays in range
            c = int'(ptr) + k;
            if (c >= NCHAN) c = c - NCHAN;
            if (!found && req[c]) begin
                found   = 1'b1;
                gnt_idx = IW'(c);
            end
        end
    end
endmodule

// File: rtl/wr_chan_arb.sv
// Multi-channel burst arbiter feeding the FIFO write port through a one-entry
// registered stage. Define WR_CHAN_ARB_STATS_EN to build the beat/stall counters.
module wr_chan_arb
    import pkg_graybin::*;
#(
    parameter int NCHAN     = 4,
    parameter int BURST_MAX = 4,
    localparam int IW = $clog2(NCHAN),
    localparam int BW = $clog2(BURST_MAX + 1)
) (
    input  logic                      wclk,
    input  logic                      wrst,
    input  logic [NCHAN-1:0]          ch_valid,
    input  logic [NCHAN*DATASIZE-1:0] ch_data,
    output logic [NCHAN-1:0]          ch_ready,
    output logic [DATASIZE-1:0]       idata,
    output logic                      wren,
    input  logic                      wr_full,
    output logic [IW-1:0]             grant_id,
    output logic                      busy,
    output logic [NCHAN*STAT_W-1:0]   stat_beats,
    output logic [STAT_W-1:0]         stat_stall
);
    arb_state_e          state_q;
    logic [IW-1:0]       owner_q, rr_q, rr_next, gnt_idx;
    logic [BW-1:0]       beat_q;
    logic [DATASIZE-1:0] idata_q;
    logic                wren_q, gnt_any;
    logic                drain, can_load, own_valid, accept;

    rr_pick #(.NCHAN(NCHAN)) u_pick (
        .req     (ch_valid),
        .ptr     (rr_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign drain     = wren_q && !wr_full;
    assign can_load  = !wren_q || drain;
    assign own_valid = ch_valid[owner_q];
    assign accept    = (state_q == ARB_BURST) && can_load && own_valid;
    assign rr_next   = (owner_q == IW'(NCHAN-1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        ch_ready = '0;
        if (state_q == ARB_BURST && can_load) ch_ready[owner_q] = 1'b1;
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: if (gnt_any) begin
                    owner_q <= gnt_idx;
                    beat_q  <= '0;
                    state_q <= ARB_BURST;
                end
                ARB_BURST: begin
                    // losing valid ends the burst even while stalled on wr_full
                    if (!own_valid) begin
                        state_q <= ARB_IDLE;
                        rr_q    <= rr_next;
                    end else if (accept) begin
                        if (beat_q == BW'(BURST_MAX-1)) begin
                            state_q <= ARB_IDLE;
                            rr_q    <= rr_next;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            idata_q <= '0;
            wren_q  <= 1'b0;
        end else if (accept) begin
            idata_q <= ch_data[owner_q*DATASIZE +: DATASIZE];
            wren_q  <= 1'b1;
        end else if (drain) begin
            wren_q  <= 1'b0;
        end
    end

    assign idata    = idata_q;
    assign wren     = wren_q;
    assign grant_id = owner_q;
    assign busy     = (state_q == ARB_BURST);

`ifdef WR_CHAN_ARB_STATS_EN
    logic [NCHAN-1:0][STAT_W-1:0] beats_q;
    logic [STAT_W-1:0]            stall_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            beats_q <= '0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++)
                if (accept && owner_q == IW'(i)) beats_q[i] <= sat_inc(beats_q[i]);
            if (wren_q && wr_full) stall_q <= sat_inc(stall_q);
        end
    end

    assign stat_beats = beats_q;
    assign stat_stall = stall_q;
`else
    assign stat_beats = '0;
    assign stat_stall = '0;
`endif
endmodule

// File: tb/tb_wr_chan_arb.sv
// Directed bench for wr_chan_arb: producer counters per channel, written-beat log.
module tb_wr_chan_arb;
    import pkg_graybin::*;
    localparam int NCHAN = 4;
    localparam int DW    = DATASIZE;

    logic                   wclk, wrst, wren, wr_full, busy;
    logic [NCHAN-1:0]       ch_valid, ch_ready;
    logic [NCHAN*DW-1:0]    ch_data;
    logic [DW-1:0]          idata;
    logic [1:0]             grant_id;
    logic [NCHAN*STAT_W-1:0] stat_beats;
    logic [STAT_W-1:0]      stat_stall;

    int vecs = 0, miss = 0;
    int cnt[NCHAN], lim[NCHAN];
    logic [7:0] wlog[$];

    wr_chan_arb #(.NCHAN(NCHAN), .BURST_MAX(4)) dut (
        .wclk(wclk), .wrst(wrst), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .idata(idata), .wren(wren), .wr_full(wr_full),
        .grant_id(grant_id), .busy(busy), .stat_beats(stat_beats), .stat_stall(stat_stall)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // channel i emits 8'hA0 + 16*i + beat_index while beats remain
    task automatic drive();
        for (int i = 0; i < NCHAN; i++) begin
            ch_valid[i] = (cnt[i] < lim[i]);
            ch_data[i*DW +: DW] = 8'(8'hA0 + 16*i + cnt[i]);
        end
    endtask

    task automatic tick();
        logic [NCHAN-1:0] acc;
        @(negedge wclk);
        acc = ch_valid & ch_ready;
        if (wren && !wr_full) wlog.push_back(idata);
        @(posedge wclk);
        #1;
        for (int i = 0; i < NCHAN; i++) if (acc[i]) cnt[i]++;
        drive();
    endtask

    task automatic do_reset();
        wrst = 1'b1; wr_full = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin cnt[i] = 0; lim[i] = 0; end
        drive();
        tick(); tick();
        wrst = 1'b0;
        wlog.delete();
    endtask

    task automatic test_reset();
        wrst = 1'b1; wr_full = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin cnt[i] = 0; lim[i] = 5; end
        drive();
        tick(); tick();
        vecs++; if (wren !== 1'b0) begin miss++; $display("FAIL reset_wren got %b exp 0", wren); end
        vecs++; if (idata !== 8'h00) begin miss++; $display("FAIL reset_idata got %h exp 00", idata); end
        vecs++; if (ch_ready !== 4'b0) begin miss++; $display("FAIL reset_ready got %b exp 0000", ch_ready); end
        vecs++; if (busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %b exp 0", busy); end
        vecs++; if (grant_id !== 2'd0) begin miss++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
        vecs++; if (stat_beats !== '0 || stat_stall !== '0) begin
            miss++; $display("FAIL reset_stats got %h/%h exp 0", stat_beats, stat_stall); end
    endtask

    task automatic test_single();
        logic [9:0] ew, eb;
        logic [7:0] ed;
        ew = 10'b0011011110;
        eb = 10'b0011101111;
        ed = 8'hA0;
        do_reset();
        lim[0] = 6; drive();
        for (int k = 1; k <= 10; k++) begin
            tick();
            vecs++; if (wren !== ew[k-1]) begin miss++; $display("FAIL single_wren k=%0d got %b exp %b", k, wren, ew[k-1]); end
            vecs++; if (busy !== eb[k-1]) begin miss++; $display("FAIL single_busy k=%0d got %b exp %b", k, busy, eb[k-1]); end
            if (ew[k-1]) begin
                vecs++; if (idata !== ed) begin miss++; $display("FAIL single_data k=%0d got %h exp %h", k, idata, ed); end
                ed = ed + 8'd1;
            end
            if (eb[k-1]) begin
                vecs++; if (grant_id !== 2'd0) begin miss++; $display("FAIL single_grant k=%0d got %0d exp 0", k, grant_id); end
            end
        end
    endtask

    task automatic test_all();
        logic ewk;
        logic [7:0] ed;
        int b;
        do_reset();
        for (int i = 0; i < NCHAN; i++) lim[i] = 100;
        drive();
        for (int k = 1; k <= 22; k++) begin
            tick();
            ewk = (k >= 2) && ((k - 2) % 5 != 4);
            vecs++; if (wren !== ewk) begin miss++; $display("FAIL all_wren k=%0d got %b exp %b", k, wren, ewk); end
            if (k >= 2 && (k - 2) % 5 == 0) begin
                vecs++; if (busy !== 1'b1 || grant_id !== 2'(((k - 2) / 5) % 4)) begin
                    miss++; $display("FAIL all_grant k=%0d got %b/%0d exp 1/%0d", k, busy, grant_id, ((k - 2) / 5) % 4); end
            end
        end
        vecs++; if (wlog.size() != 16) begin miss++; $display("FAIL all_count got %0d exp 16", wlog.size()); end
        for (int j = 0; j < 16 && j < wlog.size(); j++) begin
            b  = j / 4;
            ed = 8'(8'hA0 + 16 * (b % 4) + j % 4);
            vecs++; if (wlog[j] !== ed) begin miss++; $display("FAIL all_data j=%0d got %h exp %h", j, wlog[j], ed); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        lim[0] = 4; drive();
        tick(); tick(); tick();
        vecs++; if (wren !== 1'b1 || idata !== 8'hA1) begin miss++; $display("FAIL stall_pre got %b/%h exp 1/a1", wren, idata); end
        wr_full = 1'b1;
        #1;
        for (int s = 0; s < 5; s++) begin
            tick();
            vecs++; if (wren !== 1'b1 || idata !== 8'hA1 || ch_ready !== 4'b0) begin
                miss++; $display("FAIL stall_hold s=%0d got %b/%h/%b exp 1/a1/0000", s, wren, idata, ch_ready); end
        end
        wr_full = 1'b0;
        tick();
        vecs++; if (wren !== 1'b1 || idata !== 8'hA2 || busy !== 1'b1) begin
            miss++; $display("FAIL stall_resume3 got %b/%h/%b exp 1/a2/1", wren, idata, busy); end
        tick();
        vecs++; if (wren !== 1'b1 || idata !== 8'hA3 || busy !== 1'b0) begin
            miss++; $display("FAIL stall_resume4 got %b/%h/%b exp 1/a3/0", wren, idata, busy); end
        tick(); tick();
        vecs++; if (wlog.size() != 4) begin miss++; $display("FAIL stall_count got %0d exp 4", wlog.size()); end
        for (int j = 0; j < 4 && j < wlog.size(); j++) begin
            vecs++; if (wlog[j] !== 8'(8'hA0 + j)) begin miss++; $display("FAIL stall_data j=%0d got %h exp %h", j, wlog[j], 8'(8'hA0 + j)); end
        end
`ifdef WR_CHAN_ARB_STATS_EN
        vecs++; if (stat_stall !== 16'd5) begin miss++; $display("FAIL stall_stat got %0d exp 5", stat_stall); end
        vecs++; if (stat_beats[15:0] !== 16'd4) begin miss++; $display("FAIL stall_beats got %0d exp 4", stat_beats[15:0]); end
`else
        vecs++; if (stat_stall !== 16'd0 || stat_beats !== '0) begin
            miss++; $display("FAIL stall_stat_off got %h/%h exp 0", stat_stall, stat_beats); end
`endif
    endtask

    task automatic test_drop();
        logic [7:0] exp_log[7];
        exp_log = '{8'hA0, 8'hA1, 8'hC0, 8'hC1, 8'hD0, 8'hA2, 8'hA3};
        do_reset();
        lim[0] = 2; lim[2] = 2; drive();
        for (int k = 1; k <= 3; k++) begin
            tick();
            vecs++; if ((ch_ready & 4'b1110) !== 4'b0) begin miss++; $display("FAIL drop_nonowner k=%0d got %b exp 0", k, ch_ready); end
        end
        tick();
        vecs++; if (busy !== 1'b0) begin miss++; $display("FAIL drop_idle got %b exp 0", busy); end
        tick();
        vecs++; if (busy !== 1'b1 || grant_id !== 2'd2) begin miss++; $display("FAIL drop_grant2 got %b/%0d exp 1/2", busy, grant_id); end
        tick(); tick(); tick();
        lim[0] = 4; lim[3] = 1; drive();
        tick();
        vecs++; if (busy !== 1'b1 || grant_id !== 2'd3) begin miss++; $display("FAIL drop_grant3 got %b/%0d exp 1/3", busy, grant_id); end
        for (int k = 10; k <= 16; k++) tick();
        vecs++; if (wlog.size() != 7) begin miss++; $display("FAIL drop_count got %0d exp 7", wlog.size()); end
        for (int j = 0; j < 7 && j < wlog.size(); j++) begin
            vecs++; if (wlog[j] !== exp_log[j]) begin miss++; $display("FAIL drop_data j=%0d got %h exp %h", j, wlog[j], exp_log[j]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lim[1] = 1; drive();
        tick(); tick(); tick();
        lim[2] = 4; drive();
        tick(); tick();
        wr_full = 1'b1;
        tick();
        vecs++; if (wren !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd2) begin
            miss++; $display("FAIL rmid_pre got %b/%b/%0d exp 1/1/2", wren, busy, grant_id); end
        wrst = 1'b1;
        tick();
        vecs++; if (wren !== 1'b0 || busy !== 1'b0 || ch_ready !== 4'b0) begin
            miss++; $display("FAIL rmid_after got %b/%b/%b exp 0/0/0000", wren, busy, ch_ready); end
        vecs++; if (stat_beats !== '0 || stat_stall !== '0) begin
            miss++; $display("FAIL rmid_stats got %h/%h exp 0", stat_beats, stat_stall); end
        wrst = 1'b0; wr_full = 1'b0;
        lim[2] = cnt[2]; lim[0] = 1; lim[3] = 1; drive();
        wlog.delete();
        tick();
        vecs++; if (busy !== 1'b1 || grant_id !== 2'd0) begin miss++; $display("FAIL rmid_rr got %b/%0d exp 1/0", busy, grant_id); end
        tick(); tick(); tick();
        vecs++; if (wlog.size() < 1 || wlog[0] !== 8'hA0) begin
            miss++; $display("FAIL rmid_first got %h exp a0", (wlog.size() > 0) ? wlog[0] : 8'hxx); end
    endtask

`ifdef WR_CHAN_ARB_STATS_EN
    task automatic test_sat();
        int budget;
        do_reset();
        lim[1] = 70000; drive();
        budget = 90000;
        while (cnt[1] < 65540 && budget > 0) begin
            tick();
            if (wlog.size() > 64) wlog.delete();
            budget--;
        end
        vecs++; if (budget == 0) begin miss++; $display("FAIL sat_timeout got %0d beats exp 65540", cnt[1]); end
        vecs++; if (stat_beats[31:16] !== 16'hFFFF) begin miss++; $display("FAIL sat_ch1 got %h exp ffff", stat_beats[31:16]); end
        vecs++; if (stat_beats[15:0] !== 16'h0 || stat_beats[63:32] !== 32'h0) begin
            miss++; $display("FAIL sat_others got %h exp 0", stat_beats); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all();
        test_stall();
        test_drop();
        test_reset_mid();
`ifdef WR_CHAN_ARB_STATS_EN
        test_sat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
